// File: rtl/lock_supervisor.sv
// Supervisor for the 3-bit serial combination-lock engine: sequences the
// engine's valid/reset, holds the key, counts consecutive failures, imposes a
// timed lockout and holds the door open for a bounded time.
module lock_supervisor #(
  parameter int unsigned         KEY_W       = 3,
  parameter int unsigned         MAX_FAILS   = 3,
  parameter int unsigned         LOCKOUT_CYC = 16,
  parameter int unsigned         UNLOCK_CYC  = 8,
  parameter logic [KEY_W-1:0]    DEFAULT_KEY = 3'b101
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               att_unlock,
  input  logic                               att_error,
  input  logic                               prog_req,
  input  logic [KEY_W-1:0]                   prog_key,
  input  logic                               relock,
  output logic                               lock_valid,
  output logic                               lock_rst,
  output logic [KEY_W-1:0]                   lock_key,
  output logic                               door_open,
  output logic                               locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt,
  output logic [2:0]                         sup_state
);

  localparam int unsigned FW   = $clog2(MAX_FAILS + 1);
  localparam int unsigned TMAX = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_CLEAR   = 3'd0,
    S_ARMED   = 3'd1,
    S_OPEN    = 3'd2,
    S_PROG    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    fail_q, fail_d, fail_inc;
  logic [TW-1:0]    timer_q, timer_d;
  logic [KEY_W-1:0] key_q, key_d;

  assign fail_cnt = fail_q;
  assign lock_key = key_q;

  // Next-state, failure counter, timer and key update.
  always_comb begin
    state_d  = state_q;
    fail_d   = fail_q;
    timer_d  = timer_q;
    key_d    = key_q;
    fail_inc = (fail_q == FW'(MAX_FAILS)) ? fail_q : fail_q + FW'(1);
    case (state_q)
      S_CLEAR: state_d = S_ARMED;
      S_ARMED: begin
        // Error wins over a simultaneous unlock indication.
        if (att_error) begin
          fail_d = fail_inc;
          if (fail_inc == FW'(MAX_FAILS)) begin
            state_d = S_LOCKOUT;
            timer_d = TW'(LOCKOUT_CYC - 1);
          end else begin
            state_d = S_CLEAR;
          end
        end else if (att_unlock) begin
          state_d = S_OPEN;
          fail_d  = '0;
          timer_d = TW'(UNLOCK_CYC - 1);
        end
      end
      S_OPEN: begin
        // Relock wins over a simultaneous programming request.
        if (relock || timer_q == '0) begin
          state_d = S_CLEAR;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
          if (prog_req) state_d = S_PROG;
        end
      end
      S_PROG: begin
        key_d   = prog_key;
        state_d = S_CLEAR;
        timer_d = '0;
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = S_CLEAR;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // State/counter registers plus outputs decoded from the next state so the
  // outputs are registered yet track the state with no extra cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      fail_q     <= '0;
      timer_q    <= '0;
      key_q      <= DEFAULT_KEY;
      lock_valid <= 1'b1;
      lock_rst   <= 1'b1;
      door_open  <= 1'b0;
      locked_out <= 1'b0;
      sup_state  <= S_CLEAR;
    end else begin
      state_q    <= state_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      key_q      <= key_d;
      lock_valid <= (state_d == S_CLEAR) || (state_d == S_ARMED);
      lock_rst   <= (state_d == S_CLEAR);
      door_open  <= (state_d == S_OPEN) || (state_d == S_PROG);
      locked_out <= (state_d == S_LOCKOUT);
      sup_state  <= state_d;
    end
  end

endmodule

// File: tb/tb_lock_supervisor.sv
// Directed testbench for lock_supervisor with default parameters.
module tb_lock_supervisor;

  logic       clk = 1'b0;
  logic       reset;
  logic       att_unlock, att_error, prog_req, relock;
  logic [2:0] prog_key;
  logic       lock_valid, lock_rst, door_open, locked_out;
  logic [2:0] lock_key;
  logic [1:0] fail_cnt;
  logic [2:0] sup_state;

  int vecs = 0;
  int errs = 0;

  // {sup_state, lock_valid, lock_rst, door_open, locked_out}
  logic [6:0] obs;
  assign obs = {sup_state, lock_valid, lock_rst, door_open, locked_out};

  localparam logic [6:0] ST_CLEAR   = 7'b000_1100;
  localparam logic [6:0] ST_ARMED   = 7'b001_1000;
  localparam logic [6:0] ST_OPEN    = 7'b010_0010;
  localparam logic [6:0] ST_PROG    = 7'b011_0010;
  localparam logic [6:0] ST_LOCKOUT = 7'b100_0001;

  lock_supervisor #(
    .KEY_W(3), .MAX_FAILS(3), .LOCKOUT_CYC(16), .UNLOCK_CYC(8), .DEFAULT_KEY(3'b101)
  ) dut (
    .clk(clk), .reset(reset), .att_unlock(att_unlock), .att_error(att_error),
    .prog_req(prog_req), .prog_key(prog_key), .relock(relock),
    .lock_valid(lock_valid), .lock_rst(lock_rst), .lock_key(lock_key),
    .door_open(door_open), .locked_out(locked_out), .fail_cnt(fail_cnt),
    .sup_state(sup_state)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; att_unlock = 1'b0; att_error = 1'b0;
    prog_req = 1'b0; relock = 1'b0; prog_key = 3'b000;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    vecs++; if (obs !== ST_CLEAR) begin errs++; $display("FAIL reset_state: got %b want %b", obs, ST_CLEAR); end
    vecs++; if (lock_key !== 3'b101) begin errs++; $display("FAIL reset_key: got %b want 101", lock_key); end
    vecs++; if (fail_cnt !== 2'd0) begin errs++; $display("FAIL reset_fail: got %0d want 0", fail_cnt); end
    @(negedge clk);
    vecs++; if (obs !== ST_ARMED) begin errs++; $display("FAIL reset_armed: got %b want %b", obs, ST_ARMED); end
    @(negedge clk);
    vecs++; if (obs !== ST_ARMED) begin errs++; $display("FAIL armed_hold: got %b want %b", obs, ST_ARMED); end
  endtask

  task automatic test_unlock();
    att_unlock = 1'b1;
    @(negedge clk);
    att_unlock = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vecs++; if (obs !== ST_OPEN) begin errs++; $display("FAIL open_cycle%0d: got %b want %b", i, obs, ST_OPEN); end
      @(negedge clk);
    end
    vecs++; if (obs !== ST_CLEAR) begin errs++; $display("FAIL open_timeout: got %b want %b", obs, ST_CLEAR); end
    @(negedge clk);
    vecs++; if (obs !== ST_ARMED) begin errs++; $display("FAIL open_rearm: got %b want %b", obs, ST_ARMED); end
  endtask

  task automatic test_lockout();
    for (int n = 1; n <= 2; n++) begin
      att_error = 1'b1;
      @(negedge clk);
      att_error = 1'b0;
      vecs++; if (obs !== ST_CLEAR) begin errs++; $display("FAIL err%0d_state: got %b want %b", n, obs, ST_CLEAR); end
      vecs++; if (fail_cnt !== 2'(n)) begin errs++; $display("FAIL err%0d_cnt: got %0d want %0d", n, fail_cnt, n); end
      @(negedge clk);
      vecs++; if (obs !== ST_ARMED) begin errs++; $display("FAIL err%0d_rearm: got %b want %b", n, obs, ST_ARMED); end
    end
    att_error = 1'b1;
    @(negedge clk);
    att_error = 1'b0;
    att_unlock = 1'b1;
    vecs++; if (fail_cnt !== 2'd3) begin errs++; $display("FAIL err3_cnt: got %0d want 3", fail_cnt); end
    for (int i = 0; i < 16; i++) begin
      vecs++; if (obs !== ST_LOCKOUT) begin errs++; $display("FAIL lockout_cycle%0d: got %b want %b", i, obs, ST_LOCKOUT); end
      @(negedge clk);
    end
    att_unlock = 1'b0;
    vecs++; if (obs !== ST_CLEAR) begin errs++; $display("FAIL lockout_end: got %b want %b", obs, ST_CLEAR); end
    vecs++; if (fail_cnt !== 2'd0) begin errs++; $display("FAIL lockout_cnt_clr: got %0d want 0", fail_cnt); end
    @(negedge clk);
    vecs++; if (obs !== ST_ARMED) begin errs++; $display("FAIL lockout_rearm: got %b want %b", obs, ST_ARMED); end
  endtask

  task automatic test_prog();
    // prog_req outside OPEN must be ignored
    prog_req = 1'b1; prog_key = 3'b000;
    @(negedge clk);
    prog_req = 1'b0;
    vecs++; if (obs !== ST_ARMED) begin errs++; $display("FAIL prog_ign_state: got %b want %b", obs, ST_ARMED); end
    vecs++; if (lock_key !== 3'b101) begin errs++; $display("FAIL prog_ign_key: got %b want 101", lock_key); end
    att_unlock = 1'b1;
    @(negedge clk);
    att_unlock = 1'b0;
    vecs++; if (obs !== ST_OPEN) begin errs++; $display("FAIL prog_open: got %b want %b", obs, ST_OPEN); end
    prog_req = 1'b1; prog_key = 3'b011;
    @(negedge clk);
    prog_req = 1'b0;
    vecs++; if (obs !== ST_PROG) begin errs++; $display("FAIL prog_state: got %b want %b", obs, ST_PROG); end
    vecs++; if (lock_key !== 3'b101) begin errs++; $display("FAIL prog_key_early: got %b want 101", lock_key); end
    @(negedge clk);
    vecs++; if (obs !== ST_CLEAR) begin errs++; $display("FAIL prog_clear: got %b want %b", obs, ST_CLEAR); end
    vecs++; if (lock_key !== 3'b011) begin errs++; $display("FAIL prog_key_new: got %b want 011", lock_key); end
    @(negedge clk);
    vecs++; if (obs !== ST_ARMED) begin errs++; $display("FAIL prog_rearm: got %b want %b", obs, ST_ARMED); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vecs++; if (obs !== ST_CLEAR) begin errs++; $display("FAIL prog_reset_state: got %b want %b", obs, ST_CLEAR); end
    vecs++; if (lock_key !== 3'b101) begin errs++; $display("FAIL prog_reset_key: got %b want 101", lock_key); end
    @(negedge clk);
  endtask

  task automatic test_priority();
    att_unlock = 1'b1; att_error = 1'b1;
    @(negedge clk);
    att_unlock = 1'b0; att_error = 1'b0;
    vecs++; if (obs !== ST_CLEAR) begin errs++; $display("FAIL both_att_state: got %b want %b", obs, ST_CLEAR); end
    vecs++; if (fail_cnt !== 2'd1) begin errs++; $display("FAIL both_att_cnt: got %0d want 1", fail_cnt); end
    @(negedge clk);
    att_unlock = 1'b1;
    @(negedge clk);
    att_unlock = 1'b0;
    vecs++; if (obs !== ST_OPEN) begin errs++; $display("FAIL unlock_open: got %b want %b", obs, ST_OPEN); end
    vecs++; if (fail_cnt !== 2'd0) begin errs++; $display("FAIL unlock_cnt_clr: got %0d want 0", fail_cnt); end
    relock = 1'b1; prog_req = 1'b1; prog_key = 3'b010;
    @(negedge clk);
    relock = 1'b0; prog_req = 1'b0;
    vecs++; if (obs !== ST_CLEAR) begin errs++; $display("FAIL relock_prio_state: got %b want %b", obs, ST_CLEAR); end
    vecs++; if (lock_key !== 3'b101) begin errs++; $display("FAIL relock_prio_key: got %b want 101", lock_key); end
    @(negedge clk);
    vecs++; if (obs !== ST_ARMED) begin errs++; $display("FAIL relock_rearm: got %b want %b", obs, ST_ARMED); end
  endtask

  task automatic test_reset_in_lockout();
    for (int n = 0; n < 3; n++) begin
      att_error = 1'b1;
      @(negedge clk);
      att_error = 1'b0;
      if (n < 2) @(negedge clk);
    end
    // now observing lockout cycle 1; advance to cycle 5
    repeat (4) @(negedge clk);
    vecs++; if (obs !== ST_LOCKOUT) begin errs++; $display("FAIL rstlo_cycle5: got %b want %b", obs, ST_LOCKOUT); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vecs++; if (obs !== ST_CLEAR) begin errs++; $display("FAIL rstlo_state: got %b want %b", obs, ST_CLEAR); end
    vecs++; if (fail_cnt !== 2'd0) begin errs++; $display("FAIL rstlo_cnt: got %0d want 0", fail_cnt); end
    @(negedge clk);
    vecs++; if (obs !== ST_ARMED) begin errs++; $display("FAIL rstlo_rearm: got %b want %b", obs, ST_ARMED); end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_prog();
    test_priority();
    test_reset_in_lockout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
